// File: rtl/pll_cfg_pkg.sv
// Shared types and the fixed reconfiguration tables for pll_reconfig_seq.
// Output 0 is the video clock and output 1 is the CPU clock. The reference
// clock is 50 MHz and N is bypassed, so VCO = 50 MHz * (M + K / 2^32).
package pll_cfg_pkg;

  typedef enum logic [1:0] {
    ST_PLLRST,
    ST_LOCK,
    ST_RUN,
    ST_WR
  } state_t;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } cfg_entry_t;

  localparam int CFG_WRITES = 7;

  // Reconfiguration controller register map
  localparam logic [5:0] REG_MODE  = 6'd0;
  localparam logic [5:0] REG_START = 6'd2;
  localparam logic [5:0] REG_N     = 6'd3;
  localparam logic [5:0] REG_M     = 6'd4;
  localparam logic [5:0] REG_C     = 6'd5;
  localparam logic [5:0] REG_K     = 6'd7;

  // Counter words: [7:0] low count, [15:8] high count, [16] bypass,
  // [17] odd division; C counters select the output in [22:18].
  // Mode 0: VCO 460 MHz (M 9.2), C0 /16 = 28.75 MHz, C1 /128 = 3.59375 MHz.
  // Mode 1: VCO 504 MHz (M 10.08), C0 /14 = 36 MHz,  C1 /126 = 4 MHz.
  localparam cfg_entry_t CFG_TABLE [2][CFG_WRITES] = '{
    '{ '{REG_MODE,  32'h0000_0000},
       '{REG_N,     32'h0001_0000},
       '{REG_M,     32'h0002_0504},
       '{REG_K,     32'h3333_3333},
       '{REG_C,     32'h0000_0808},
       '{REG_C,     32'h0004_4040},
       '{REG_START, 32'h0000_0000} },
    '{ '{REG_MODE,  32'h0000_0000},
       '{REG_N,     32'h0001_0000},
       '{REG_M,     32'h0000_0505},
       '{REG_K,     32'h147A_E147},
       '{REG_C,     32'h0000_0707},
       '{REG_C,     32'h0004_3F3F},
       '{REG_START, 32'h0000_0000} }
  };

  // Table entry for a mode and write index; out-of-range indices read as zero.
  function automatic cfg_entry_t cfg_lookup(input logic mode_sel, input logic [2:0] idx);
    if (idx < 3'(CFG_WRITES)) begin
      return CFG_TABLE[mode_sel][idx];
    end
    return '0;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Shift the asynchronous input through two flops to settle metastability.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so sync_q takes the old meta_q, giving two real stages.
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reconfig_seq.sv
// PLL reconfiguration sequencer: loads the counter table for the requested
// clock mode, supervises lock, resets the PLL on lock timeout and holds the
// core in reset while the clocks are not valid.
module pll_reconfig_seq #(
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 1048576,
  parameter int PLL_RST_CYCLES      = 16
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        mode,
  input  logic        pll_locked,
  input  logic        cfg_waitrequest,
  output logic [5:0]  cfg_address,
  output logic [31:0] cfg_writedata,
  output logic        cfg_write,
  output logic        pll_rst,
  output logic        core_reset,
  output logic        busy,
  output logic        active_mode,
  output logic        lock_error
);

  import pll_cfg_pkg::*;

  localparam int RST_W = $clog2(PLL_RST_CYCLES + 1);
  localparam int STB_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TMO_W = $clog2(LOCK_TIMEOUT_CYCLES + 1);

  logic lk;

  state_t      state_q, state_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [STB_W-1:0] stable_q, stable_d;
  logic [TMO_W-1:0] timeout_q, timeout_d;
  logic [2:0]  idx_q, idx_d;
  logic        req_q, req_d;
  logic        cfg_write_q, cfg_write_d;
  logic [5:0]  cfg_address_q, cfg_address_d;
  logic [31:0] cfg_writedata_q, cfg_writedata_d;
  logic        pll_rst_q, pll_rst_d;
  logic        core_reset_q, core_reset_d;
  logic        busy_q, busy_d;
  logic        active_mode_q, active_mode_d;
  logic        lock_error_q, lock_error_d;
  cfg_entry_t  entry;

  sync2 u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk)
  );

  // Next-state and next-output logic; outputs are derived from the next state.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned (no latches).
    state_d         = state_q;
    rst_cnt_d       = '0;
    stable_d        = '0;
    timeout_d       = '0;
    idx_d           = idx_q;
    req_d           = req_q;
    cfg_write_d     = cfg_write_q;
    cfg_address_d   = cfg_address_q;
    cfg_writedata_d = cfg_writedata_q;
    active_mode_d   = active_mode_q;
    lock_error_d    = 1'b0;
    entry           = '0;

    case (state_q)
      ST_PLLRST: begin
        if (rst_cnt_q == RST_W'(PLL_RST_CYCLES - 1)) begin
          state_d = ST_LOCK;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end

      ST_LOCK: begin
        stable_d  = lk ? stable_q + STB_W'(1) : '0;
        timeout_d = timeout_q + TMO_W'(1);
        // A stable lock wins over a coincident timeout.
        if (lk && stable_q == STB_W'(LOCK_STABLE_CYCLES - 1)) begin
          state_d = ST_RUN;
        end else if (timeout_q == TMO_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
          state_d      = ST_PLLRST;
          lock_error_d = 1'b1;
        end
      end

      ST_RUN: begin
        // Lock loss wins; a pending mode change is seen again on the next RUN.
        if (!lk) begin
          state_d = ST_LOCK;
        end else if (mode != active_mode_q) begin
          req_d           = mode;
          idx_d           = 3'd0;
          entry           = cfg_lookup(mode, 3'd0);
          cfg_write_d     = 1'b1;
          cfg_address_d   = entry.addr;
          cfg_writedata_d = entry.data;
          state_d         = ST_WR;
        end
      end

      ST_WR: begin
        if (cfg_write_q && !cfg_waitrequest) begin
          if (idx_q == 3'(CFG_WRITES - 1)) begin
            active_mode_d   = req_q;
            cfg_write_d     = 1'b0;
            cfg_address_d   = '0;
            cfg_writedata_d = '0;
            state_d         = ST_LOCK;
          end else begin
            idx_d           = idx_q + 3'd1;
            entry           = cfg_lookup(req_q, idx_q + 3'd1);
            cfg_address_d   = entry.addr;
            cfg_writedata_d = entry.data;
          end
        end
      end

      default: state_d = ST_PLLRST;
    endcase

    // Lock counters start from zero on every entry to LOCK.
    if (state_d != ST_LOCK) begin
      stable_d  = '0;
      timeout_d = '0;
    end

    // A PLL reset restores the compiled (mode 0) configuration.
    if (state_d == ST_PLLRST) begin
      active_mode_d = 1'b0;
    end

    pll_rst_d    = (state_d == ST_PLLRST);
    core_reset_d = (state_d != ST_RUN);
    busy_d       = (state_d != ST_RUN);
  end

  // State, counters and registered outputs; rst aborts any write immediately.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_PLLRST;
      rst_cnt_q       <= '0;
      stable_q        <= '0;
      timeout_q       <= '0;
      idx_q           <= '0;
      req_q           <= 1'b0;
      cfg_write_q     <= 1'b0;
      cfg_address_q   <= '0;
      cfg_writedata_q <= '0;
      pll_rst_q       <= 1'b1;
      core_reset_q    <= 1'b1;
      busy_q          <= 1'b1;
      active_mode_q   <= 1'b0;
      lock_error_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      rst_cnt_q       <= rst_cnt_d;
      stable_q        <= stable_d;
      timeout_q       <= timeout_d;
      idx_q           <= idx_d;
      req_q           <= req_d;
      cfg_write_q     <= cfg_write_d;
      cfg_address_q   <= cfg_address_d;
      cfg_writedata_q <= cfg_writedata_d;
      pll_rst_q       <= pll_rst_d;
      core_reset_q    <= core_reset_d;
      busy_q          <= busy_d;
      active_mode_q   <= active_mode_d;
      lock_error_q    <= lock_error_d;
    end
  end

  assign cfg_write     = cfg_write_q;
  assign cfg_address   = cfg_address_q;
  assign cfg_writedata = cfg_writedata_q;
  assign pll_rst       = pll_rst_q;
  assign core_reset    = core_reset_q;
  assign busy          = busy_q;
  assign active_mode   = active_mode_q;
  assign lock_error    = lock_error_q;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Bench for pll_reconfig_seq: directed scenarios with hand-computed timing,
// plus a scoreboard of expected management writes checked by a monitor.
module tb_pll_reconfig_seq;

  localparam int LSC = 1024;
  localparam int LTC = 3000;
  localparam int PRC = 16;

  logic        refclk = 1'b0;
  logic        rst;
  logic        mode;
  logic        pll_locked;
  logic        cfg_waitrequest;
  logic [5:0]  cfg_address;
  logic [31:0] cfg_writedata;
  logic        cfg_write;
  logic        pll_rst;
  logic        core_reset;
  logic        busy;
  logic        active_mode;
  logic        lock_error;

  pll_reconfig_seq #(
    .LOCK_STABLE_CYCLES  (LSC),
    .LOCK_TIMEOUT_CYCLES (LTC),
    .PLL_RST_CYCLES      (PRC)
  ) dut (
    .refclk          (refclk),
    .rst             (rst),
    .mode            (mode),
    .pll_locked      (pll_locked),
    .cfg_waitrequest (cfg_waitrequest),
    .cfg_address     (cfg_address),
    .cfg_writedata   (cfg_writedata),
    .cfg_write       (cfg_write),
    .pll_rst         (pll_rst),
    .core_reset      (core_reset),
    .busy            (busy),
    .active_mode     (active_mode),
    .lock_error      (lock_error)
  );

  always #10 refclk = ~refclk;

  int checks   = 0;
  int failures = 0;
  int accepts  = 0;
  logic [37:0] sb [$];
  logic stall_en   = 1'b0;
  int   stall_left = 3;

  logic [5:0]  exp_addr [7];
  logic [31:0] exp_data [2][7];

  typedef enum int {S_CORE, S_PLLRST, S_WRITE, S_LOCKERR} watch_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic peek(input watch_t s);
    case (s)
      S_CORE:   return core_reset;
      S_PLLRST: return pll_rst;
      S_WRITE:  return cfg_write;
      default:  return lock_error;
    endcase
  endfunction

  // Count rising edges until the watched output equals v, bounded by limit.
  task automatic edges_until(input watch_t s, input logic v, input int limit,
                             input string name, output int n);
    n = 0;
    do begin
      @(posedge refclk); #1;
      n++;
    end while (peek(s) !== v && n < limit);
    check(name, peek(s), v);
  endtask

  task automatic push_seq(input int m);
    for (int i = 0; i < 7; i++) sb.push_back({exp_addr[i], exp_data[m][i]});
  endtask

  // Hand-derived register contents for both modes.
  initial begin
    exp_addr = '{6'd0, 6'd3, 6'd4, 6'd7, 6'd5, 6'd5, 6'd2};
    exp_data[0] = '{32'h0, 32'h0001_0000, 32'h0002_0504, 32'h3333_3333,
                    32'h0000_0808, 32'h0004_4040, 32'h0};
    exp_data[1] = '{32'h0, 32'h0001_0000, 32'h0000_0505, 32'h147A_E147,
                    32'h0000_0707, 32'h0004_3F3F, 32'h0};
  end

  // Waitrequest driver: 0-5 stall cycles per write when stalls are enabled.
  initial begin
    cfg_waitrequest = 1'b0;
    forever begin
      @(posedge refclk); #1;
      if (stall_en && cfg_write) begin
        if (stall_left > 0) begin
          cfg_waitrequest = 1'b1;
          stall_left--;
        end else begin
          cfg_waitrequest = 1'b0;
          stall_left = $urandom_range(0, 5);
        end
      end else begin
        cfg_waitrequest = 1'b0;
      end
    end
  end

  // Monitor: compares each accepted write against the scoreboard and checks
  // that stalled writes hold address and data.
  initial begin
    logic        held;
    logic [5:0]  held_addr;
    logic [31:0] held_data;
    logic [37:0] exp;
    held = 1'b0;
    forever begin
      @(negedge refclk);
      if (rst) begin
        held = 1'b0;
        continue;
      end
      if (held) begin
        check("stall_write", cfg_write, 1'b1);
        check("stall_addr", cfg_address, held_addr);
        check("stall_data", cfg_writedata, held_data);
      end
      held = 1'b0;
      if (cfg_write) begin
        if (cfg_waitrequest) begin
          held      = 1'b1;
          held_addr = cfg_address;
          held_data = cfg_writedata;
        end else if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                   cfg_address, cfg_writedata);
        end else begin
          exp = sb.pop_front();
          check("wr_addr", cfg_address, exp[37:32]);
          check("wr_data", cfg_writedata, exp[31:0]);
          accepts++;
        end
      end
    end
  end

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int rise_at;
    int acc0;

    // Reset with the PLL already reporting lock
    rst = 1'b1; mode = 1'b0; pll_locked = 1'b1;
    repeat (3) @(posedge refclk); #1;
    check("rst_pll_rst", pll_rst, 1'b1);
    check("rst_core_reset", core_reset, 1'b1);
    check("rst_busy", busy, 1'b1);
    check("rst_cfg_write", cfg_write, 1'b0);
    check("rst_cfg_address", cfg_address, 6'd0);
    check("rst_cfg_writedata", cfg_writedata, 32'd0);
    check("rst_active_mode", active_mode, 1'b0);
    check("rst_lock_error", lock_error, 1'b0);
    rst = 1'b0;
    edges_until(S_PLLRST, 1'b0, 100, "pllrst_fall", n);
    check("pllrst_width", n, PRC);
    edges_until(S_CORE, 1'b0, 3 * LSC, "first_release_seen", n);
    check("first_release", n, LSC);
    check("run_busy", busy, 1'b0);
    check("run_active_mode", active_mode, 1'b0);

    // Mode 0 -> 1, no stalls
    push_seq(1);
    acc0 = accepts;
    mode = 1'b1;
    @(posedge refclk); #1;
    check("write_start", cfg_write, 1'b1);
    edges_until(S_WRITE, 1'b0, 100, "write_end", n);
    check("write_cycles", n, 7);
    check("post_write_busy", busy, 1'b1);
    check("post_write_active", active_mode, 1'b1);
    check("idle_address", cfg_address, 6'd0);
    check("idle_writedata", cfg_writedata, 32'd0);
    check("m1_accepts", accepts - acc0, 7);
    check("m1_sb_empty", sb.size(), 0);
    edges_until(S_CORE, 1'b0, 3 * LSC, "reconf_release_seen", n);
    check("reconf_release", n, LSC);

    // Mode 1 -> 0 with random waitrequest stalls
    stall_en = 1'b1;
    stall_left = 3;
    push_seq(0);
    acc0 = accepts;
    mode = 1'b0;
    edges_until(S_WRITE, 1'b1, 10, "stall_write_start", n);
    check("stall_write_latency", n, 1);
    edges_until(S_WRITE, 1'b0, 200, "stall_write_end", n);
    stall_en = 1'b0;
    check("m0_accepts", accepts - acc0, 7);
    check("m0_sb_empty", sb.size(), 0);
    check("m0_active", active_mode, 1'b0);
    edges_until(S_CORE, 1'b0, 3 * LSC, "stall_release", n);

    // One-cycle lock glitch in RUN
    pll_locked = 1'b0;
    @(posedge refclk); #1;
    pll_locked = 1'b1;
    rise_at = -1;
    n = 0;
    do begin
      @(posedge refclk); #1;
      n++;
      if (core_reset && rise_at < 0) rise_at = n + 1;
    end while (!(rise_at >= 0 && !core_reset) && n < 3 * LSC);
    check("glitch_reset_delay", rise_at, 3);
    check("glitch_release", n, LSC + 2);

    // Lock lost across reconfiguration: timeout, PLL reset, retry to mode 1
    push_seq(1);
    push_seq(1);
    acc0 = accepts;
    mode = 1'b1;
    pll_locked = 1'b0;
    edges_until(S_WRITE, 1'b1, 10, "to_write_start", n);
    edges_until(S_WRITE, 1'b0, 100, "to_write_end", n);
    check("to_active_before", active_mode, 1'b1);
    edges_until(S_LOCKERR, 1'b1, 2 * LTC, "lock_error_seen", n);
    check("timeout_cycles", n, LTC);
    check("timeout_pll_rst", pll_rst, 1'b1);
    check("timeout_active", active_mode, 1'b0);
    check("timeout_core_reset", core_reset, 1'b1);
    @(posedge refclk); #1;
    check("lock_error_pulse", lock_error, 1'b0);
    pll_locked = 1'b1;
    edges_until(S_WRITE, 1'b1, 3 * LSC, "retry_write_seen", n);
    check("retry_write_start", n, PRC + LSC);
    edges_until(S_WRITE, 1'b0, 100, "retry_write_end", n);
    check("retry_write_cycles", n, 7);
    check("retry_active", active_mode, 1'b1);
    check("retry_accepts", accepts - acc0, 14);
    check("retry_sb_empty", sb.size(), 0);
    edges_until(S_CORE, 1'b0, 3 * LSC, "retry_release", n);

    // Asynchronous reset in the middle of the write sequence (idx 3)
    push_seq(0);
    mode = 1'b0;
    edges_until(S_WRITE, 1'b1, 10, "abort_write_start", n);
    repeat (3) @(posedge refclk); #1;
    check("abort_idx3_addr", cfg_address, exp_addr[3]);
    check("abort_idx3_data", cfg_writedata, exp_data[0][3]);
    #2 rst = 1'b1;
    #1;
    check("abort_cfg_write", cfg_write, 1'b0);
    check("abort_cfg_address", cfg_address, 6'd0);
    check("abort_cfg_writedata", cfg_writedata, 32'd0);
    check("abort_pll_rst", pll_rst, 1'b1);
    check("abort_core_reset", core_reset, 1'b1);
    check("abort_busy", busy, 1'b1);
    check("abort_active", active_mode, 1'b0);
    check("abort_lock_error", lock_error, 1'b0);
    sb.delete();
    acc0 = accepts;
    repeat (2) @(posedge refclk); #1;
    rst = 1'b0;
    edges_until(S_PLLRST, 1'b0, 100, "restart_pllrst_fall", n);
    check("restart_pllrst_width", n, PRC);
    edges_until(S_CORE, 1'b0, 3 * LSC, "restart_release_seen", n);
    check("restart_release", n, LSC);
    repeat (4) @(posedge refclk); #1;
    check("restart_no_write", cfg_write, 1'b0);
    check("restart_accepts", accepts - acc0, 0);
    check("restart_active", active_mode, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_reconfig_seq.md
# pll_reconfig_seq

Runtime sequencer for the core's two-output fractional PLL (video clock on output 0, CPU clock on output 1). On a change of the requested clock mode, it writes a fixed table of counter settings into the PLL reconfiguration controller over its Avalon-MM management port, triggers the reconfiguration, and waits for a stable lock. It also supervises lock at all times, resetting the PLL on lock timeout, and holds the emulation core in reset whenever the clocks are not valid.

## Interface
Parameters:
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before the core is released.
- LOCK_TIMEOUT_CYCLES, 1048576: maximum cycles spent waiting for a stable lock before the PLL is reset.
- PLL_RST_CYCLES, 16: width of the PLL reset pulse.

Ports:
- refclk, in, 1: 50 MHz reference clock; also the management clock.
- rst, in, 1: asynchronous active-high reset.
- mode, in, 1: requested clock mode, synchronous to refclk. 0 = power-up configuration (28.75 / 3.59375 MHz); 1 = alternate table.
- pll_locked, in, 1: PLL locked output; asynchronous.
- cfg_waitrequest, in, 1: Avalon-MM waitrequest from the reconfiguration controller.
- cfg_address, out, 6: management register address.
- cfg_writedata, out, 32: management write data.
- cfg_write, out, 1: management write strobe.
- pll_rst, out, 1: PLL reset.
- core_reset, out, 1: core reset; high while the clocks are not valid.
- busy, out, 1: high in every state except RUN.
- active_mode, out, 1: mode currently loaded into the PLL.
- lock_error, out, 1: one-cycle pulse on lock timeout.

## Operation
- pll_locked passes through a 2-FF synchronizer; only the synchronized version (lk) is used.
- The state machine has four states: PLLRST, LOCK, RUN and WR.
- PLLRST:
  - pll_rst=1 and core_reset=1.
  - Counts PLL_RST_CYCLES, then goes to LOCK.
  - Clears active_mode to 0, because a PLL reset restores the compiled configuration.
- LOCK:
  - The stable counter increments while lk=1 and clears to 0 when lk=0.
  - The timeout counter increments every cycle.
  - Stable counter reaches LOCK_STABLE_CYCLES-1 with lk=1: go to RUN.
  - Timeout counter reaches LOCK_TIMEOUT_CYCLES-1: go to PLLRST and pulse lock_error.
  - If both conditions occur in the same cycle, the stable condition wins.
- RUN:
  - core_reset=0 and busy=0.
  - lk=0 goes to LOCK (lock loss), with core_reset=1 from the next cycle.
  - Otherwise, mode != active_mode latches mode into req and goes to WR with idx=0.
  - If lock loss and a mode change occur together, lock loss wins; the mode change is re-evaluated in the next RUN.
- WR:
  - Drives cfg_write=1 with the address and data from entry idx of the req table.
  - The write is accepted on a rising edge where cfg_write=1 and cfg_waitrequest=0.
  - After an accepted write: idx is incremented; the address and data of the next entry are presented in the following cycle with cfg_write held high.
  - When the last entry is accepted: active_mode←req, cfg_write←0, and the state goes to LOCK.
  - The LOCK stable and timeout counters are cleared on every entry to LOCK.
- Table (7 writes per mode, in order):
  - mode register: address 0, data 0 (waitrequest mode).
  - N counter: address 3.
  - M counter: address 4.
  - fractional K: address 7.
  - C0: address 5, data[22:18]=0.
  - C1: address 5, data[22:18]=1.
  - start: address 2, data 0.
- mode changes are ignored while in WR, LOCK or PLLRST; they are evaluated only in RUN.
- While cfg_write=0, cfg_address and cfg_writedata are 0.

## Timing
- Reset values:
  - state=PLLRST, pll_rst=1, core_reset=1, busy=1.
  - cfg_write=0, cfg_address=0, cfg_writedata=0.
  - active_mode=0, lock_error=0, all counters 0.
- Asynchronous rst aborts any state, including mid-write. cfg_write drops immediately; the controller tolerates an abandoned write.
- All outputs are registered.
- Lock-to-release latency: pll_locked rises at cycle t; core_reset falls at t+2+LOCK_STABLE_CYCLES, provided lk stays high throughout.
- RUN→WR: cfg_write rises in the cycle after the mode mismatch is sampled.
- Write throughput: with waitrequest always 0, the sequence takes exactly 7 cycles of cfg_write=1.
- Each waitrequest-high cycle extends the current write by one cycle, with address and data held stable.

## Structure
- Package pll_cfg_pkg holds:
  - the state enum;
  - the cfg_entry_t struct (6-bit address, 32-bit data);
  - the localparam CFG_TABLE[2][7] with the counter values for both modes;
  - the register address constants.
- Sub-module sync2: a 2-FF synchronizer with asynchronous active-high reset, reused for pll_locked.

## Test plan
- Reset release with pll_locked tied to 1: pll_rst high for 16 cycles, then core_reset falls after 1024+2 cycles of lock; active_mode=0.
- In RUN, mode 0→1 with waitrequest=0: 7 consecutive writes, with addresses 0,3,4,7,5,5,2 and mode-1 data. Then busy stays high until the new stable lock, and active_mode=1.
- Random waitrequest stalls of 0–5 cycles per write: address and data stay stable while stalled, and each table entry is accepted exactly once.
- pll_locked glitches low for 1 cycle in RUN: core_reset=1 within 3 cycles, and release occurs 1024 cycles after lk returns.
- pll_locked held 0 after reconfiguration: lock_error pulses at timeout, PLLRST is re-entered, active_mode=0, and the controller then reconfigures back to mode 1.
- rst asserted mid-WR (idx=3): all outputs return to their reset values asynchronously, and the sequence restarts cleanly after release.
